// File: rtl/mem_txn_fsm.sv
// rtl/mem_txn_fsm.sv - memory-side transaction engine (QSPI launch, byte streaming, read buffer)
// Optional stall watchdog: define MEM_TXN_TIMEOUT_EN.
module mem_txn_fsm #(
    parameter int MAX_LEN    = 256,
    parameter int RBUF_DEPTH = 4
`ifdef MEM_TXN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic        i_r_w,
    input  logic        i_address_valid,
    input  logic [23:0] i_address,
    input  logic        i_length_valid,
    input  logic [8:0]  i_length,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic        o_txn_done,
    output logic        o_len_err,
    output logic        o_timeout,
    output logic        o_q_cmd_valid,
    input  logic        i_q_cmd_ready,
    output logic        o_q_rw,
    output logic [23:0] o_q_addr,
    output logic [8:0]  o_q_len,
    output logic [7:0]  o_q_wdata,
    output logic        o_q_wvalid,
    input  logic        i_q_wready,
    input  logic [7:0]  i_q_rdata,
    input  logic        i_q_rvalid,
    input  logic        i_q_done
);
    localparam int         PW         = $clog2(RBUF_DEPTH);
    localparam logic [8:0] LP_MAX_LEN = 9'(MAX_LEN);
    localparam logic [PW:0] LP_DEPTH  = (PW+1)'(RBUF_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_ISSUE, S_WDATA, S_RDATA, S_DRAIN} state_t;
    state_t r_state, w_state_nxt;

    logic [23:0]   r_addr;
    logic [8:0]    r_len;
    logic          r_len_seen;
    logic          r_rw;
    logic [8:0]    r_cnt;
    logic          r_qdone;
    logic          r_len_err;
    logic [7:0]    r_buf [RBUF_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;

    logic w_len_take, w_len_clamp, w_cmd_hs, w_wr_hs, w_full;
    logic w_push, w_drop, w_pop, w_byte_hs, w_last, w_timeout_hit;

    assign w_len_take  = i_length_valid &&
                         ((r_state == S_IDLE && i_address_valid) || r_state == S_ARM);
    assign w_len_clamp = i_length > LP_MAX_LEN;
    assign w_cmd_hs    = o_q_cmd_valid && i_q_cmd_ready;
    assign w_wr_hs     = o_q_wvalid && i_q_wready;
    assign w_full      = r_count == LP_DEPTH;
    assign w_push      = i_q_rvalid && r_state == S_RDATA && !w_full;
    assign w_drop      = i_q_rvalid && !w_push;
    assign w_pop       = o_rd_valid && i_rd_ready;
    assign w_byte_hs   = w_wr_hs || w_push;
    assign w_last      = (r_cnt + 9'd1) == r_len;

    assign o_txn_done    = r_state == S_IDLE;
    assign o_q_cmd_valid = r_state == S_ISSUE;
    assign o_q_rw        = r_rw;
    assign o_q_addr      = r_addr;
    assign o_q_len       = r_len;
    assign o_len_err     = r_len_err;
    assign o_q_wvalid    = r_state == S_WDATA && i_wr_valid;
    assign o_wr_ready    = r_state == S_WDATA && i_q_wready;
    assign o_q_wdata     = (r_state == S_WDATA) ? i_wr_data : 8'h00;
    assign o_rd_valid    = r_count != '0;
    assign o_rd_data     = o_rd_valid ? r_buf[r_rptr] : 8'h00;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_address_valid) w_state_nxt = S_ARM;
            S_ARM:   if (i_ena && r_len_seen) w_state_nxt = (r_len == 9'd0) ? S_IDLE : S_ISSUE;
            S_ISSUE: if (w_cmd_hs) w_state_nxt = r_rw ? S_RDATA : S_WDATA;
            S_WDATA: if (w_wr_hs && w_last) w_state_nxt = S_DRAIN;
            S_RDATA: if (w_push && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if ((r_qdone || i_q_done) && r_count == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout_hit) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_len_seen <= 1'b0;
            r_rw       <= 1'b0;
            r_cnt      <= '0;
            r_qdone    <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_address_valid) begin
                r_addr     <= i_address;
                r_len_seen <= 1'b0;
            end
            if (w_len_take) begin
                r_len      <= w_len_clamp ? LP_MAX_LEN : i_length;
                r_len_seen <= 1'b1;
            end
            if ((w_len_take && w_len_clamp) || w_drop) r_len_err <= 1'b1;
            if (i_q_done) r_qdone <= 1'b1;
            // Per-transfer state is reset as the command is launched.
            if (r_state == S_ARM && w_state_nxt == S_ISSUE) begin
                r_rw    <= i_r_w;
                r_cnt   <= '0;
                r_qdone <= 1'b0;
            end else if (w_byte_hs) begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_timeout_hit) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_buf[r_wptr] <= i_q_rdata;
    end

`ifdef MEM_TXN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic            w_active, w_progress;

    assign w_active      = r_state inside {S_ISSUE, S_WDATA, S_RDATA, S_DRAIN};
    assign w_progress    = w_byte_hs || w_pop || w_cmd_hs || i_q_done;
    assign w_timeout_hit = w_active && !w_progress && r_to_cnt == TO_W'(TIMEOUT_CYC - 1);
    assign o_timeout     = r_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_active || w_progress || w_state_nxt != r_state) r_to_cnt <= '0;
            else                                                   r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign o_timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_mem_txn_fsm.sv
// tb/tb_mem_txn_fsm.sv - randomized self-checking bench for mem_txn_fsm
module tb_mem_txn_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ena, r_w, address_valid, length_valid, wr_valid, rd_ready;
    logic [23:0] address;
    logic [8:0]  length;
    logic [7:0]  wr_data, q_rdata;
    logic        q_cmd_ready, q_wready, q_rvalid, q_done;
    logic        wr_ready, rd_valid, txn_done, len_err, timeout;
    logic        q_cmd_valid, q_rw, q_wvalid;
    logic [7:0]  rd_data, q_wdata;
    logic [23:0] q_addr;
    logic [8:0]  q_len;

    int n_vec = 0;
    int n_err = 0;

    mem_txn_fsm #(
        .MAX_LEN(256), .RBUF_DEPTH(4)
`ifdef MEM_TXN_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_r_w(r_w),
        .i_address_valid(address_valid), .i_address(address),
        .i_length_valid(length_valid), .i_length(length),
        .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_txn_done(txn_done), .o_len_err(len_err), .o_timeout(timeout),
        .o_q_cmd_valid(q_cmd_valid), .i_q_cmd_ready(q_cmd_ready),
        .o_q_rw(q_rw), .o_q_addr(q_addr), .o_q_len(q_len),
        .o_q_wdata(q_wdata), .o_q_wvalid(q_wvalid), .i_q_wready(q_wready),
        .i_q_rdata(q_rdata), .i_q_rvalid(q_rvalid), .i_q_done(q_done)
    );

    // Reference model state: bytes offered in order vs bytes delivered in order.
    logic [7:0]  q_sent[$];
    logic [7:0]  q_got[$];
    int          max_occ, first_send_cyc, first_rv_cyc, cmd_lat, w_extra;
    logic [23:0] cap_addr;
    logic [8:0]  cap_len;
    logic        cap_rw, cap_seen, cap_done_after;

    task automatic open_txn(input logic [23:0] a, input logic [8:0] len, input logic rw,
                            input bit accept, input bit now);
        if (!now) @(negedge clk);
        address_valid = 1'b1; address = a; length_valid = 1'b1; length = len;
        r_w = rw; ena = 1'b1;
        @(negedge clk);
        address_valid = 1'b0; length_valid = 1'b0;
        address = 24'($urandom); length = 9'($urandom);
        #1 cap_done_after = txn_done;
        cap_seen = 1'b0; cmd_lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) begin @(negedge clk); #1; end
            if (q_cmd_valid) begin
                cap_seen = 1'b1; cmd_lat = i + 0;
                cap_addr = q_addr; cap_len = q_len; cap_rw = q_rw;
                break;
            end
        end
        if (cap_seen && accept) begin
            q_cmd_ready = 1'b1;
            @(negedge clk);
            q_cmd_ready = 1'b0;
        end
    endtask

    task automatic stream_read(input int n, input int stall_at, input int stall_cyc);
        int outst = 0, sent = 0, cyc = 0, stall_left = stall_cyc;
        q_sent.delete(); q_got.delete();
        max_occ = 0; first_send_cyc = -1; first_rv_cyc = -1;
        while (q_got.size() < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ena = 1'($urandom);
            if (q_got.size() >= stall_at && stall_left > 0) begin
                rd_ready = 1'b0; stall_left--;
            end else rd_ready = 1'b1;
            q_rvalid = (sent < n && outst < 4 && $urandom_range(0, 3) != 0);
            q_rdata  = 8'($urandom);
            #1;
            if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (rd_valid && rd_ready) begin q_got.push_back(rd_data); outst--; end
            if (q_rvalid) begin
                q_sent.push_back(q_rdata); sent++; outst++;
                if (first_send_cyc < 0) first_send_cyc = cyc;
            end
            if (outst > max_occ) max_occ = outst;
        end
        q_rvalid = 1'b0; rd_ready = 1'b1;
    endtask

    task automatic stream_write(input int n, input bit toggle);
        int cmd_hs = 0, cyc = 0;
        q_sent.delete(); q_got.delete();
        while (cmd_hs < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            ena      = 1'($urandom);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = 8'($urandom);
            q_wready = toggle ? cyc[0] : 1'b1;
            #1;
            if (wr_valid && wr_ready) begin q_sent.push_back(wr_data); cmd_hs++; end
            if (q_wvalid && q_wready) q_got.push_back(q_wdata);
        end
        w_extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = 8'($urandom); q_wready = 1'b1;
            #1;
            if (q_wvalid) w_extra++;
            if (wr_ready) w_extra++;
        end
        wr_valid = 1'b0; q_wready = 1'b0;
    endtask

    task automatic finish_txn(output int lat);
        @(negedge clk);
        q_done = 1'b1;
        @(negedge clk);
        q_done = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (txn_done) begin lat = i; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (txn_done !== 1'b1) begin n_err++; $display("FAIL reset_txn_done: got %b expected 1", txn_done); end
        n_vec++; if ({q_cmd_valid, rd_valid, wr_ready, q_wvalid, len_err, timeout, q_rw} !== 7'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000000",
                              {q_cmd_valid, rd_valid, wr_ready, q_wvalid, len_err, timeout, q_rw}); end
        n_vec++; if ({q_addr, q_len, rd_data} !== 41'b0) begin
            n_err++; $display("FAIL reset_fields: got %h expected 0", {q_addr, q_len, rd_data}); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic check_read(input string tag, input int n);
        n_vec++; if (q_got.size() != n || q_sent.size() != n) begin
            n_err++; $display("FAIL %s_count: got %0d/%0d expected %0d", tag, q_got.size(), q_sent.size(), n); end
        for (int i = 0; i < q_got.size() && i < q_sent.size(); i++) begin
            n_vec++; if (q_got[i] !== q_sent[i]) begin
                n_err++; $display("FAIL %s_data[%0d]: got %h expected %h", tag, i, q_got[i], q_sent[i]); end
        end
    endtask

    task automatic test_read16;
        int lat;
        open_txn(24'h001234, 9'd16, 1'b1, 1'b1, 1'b0);
        n_vec++; if (cmd_lat != 2) begin n_err++; $display("FAIL rd16_cmd_lat: got %0d expected 2", cmd_lat); end
        n_vec++; if (cap_done_after !== 1'b0) begin n_err++; $display("FAIL rd16_done_fall: got %b expected 0", cap_done_after); end
        n_vec++; if ({cap_addr, cap_len, cap_rw} !== {24'h001234, 9'd16, 1'b1}) begin
            n_err++; $display("FAIL rd16_cmd: got %h/%0d/%b expected 001234/16/1", cap_addr, cap_len, cap_rw); end
        stream_read(16, 99, 0);
        check_read("rd16", 16);
        n_vec++; if (first_rv_cyc - first_send_cyc != 1) begin
            n_err++; $display("FAIL rd16_latency: got %0d expected 1", first_rv_cyc - first_send_cyc); end
        finish_txn(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL rd16_done_lat: got %0d expected 1", lat); end
        n_vec++; if (len_err !== 1'b0) begin n_err++; $display("FAIL rd16_len_err: got %b expected 0", len_err); end
    endtask

    task automatic test_write32;
        int lat;
        open_txn(24'($urandom), 9'd32, 1'b0, 1'b1, 1'b0);
        n_vec++; if ({cap_seen, cap_len, cap_rw} !== {1'b1, 9'd32, 1'b0}) begin
            n_err++; $display("FAIL wr32_cmd: got %b/%0d/%b expected 1/32/0", cap_seen, cap_len, cap_rw); end
        stream_write(32, 1'b1);
        check_read("wr32", 32);
        n_vec++; if (w_extra != 0) begin n_err++; $display("FAIL wr32_extra: got %0d expected 0", w_extra); end
        finish_txn(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL wr32_done_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_read_backpressure;
        int lat;
        open_txn(24'($urandom), 9'd32, 1'b1, 1'b1, 1'b0);
        stream_read(32, 12, 10);
        check_read("rdbp", 32);
        n_vec++; if (max_occ != 4) begin n_err++; $display("FAIL rdbp_fill: got %0d expected 4", max_occ); end
        n_vec++; if (len_err !== 1'b0) begin n_err++; $display("FAIL rdbp_len_err: got %b expected 0", len_err); end
        finish_txn(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL rdbp_done_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_len_clamp;
        int lat;
        open_txn(24'($urandom), 9'd300, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cap_len !== 9'd256) begin n_err++; $display("FAIL clamp_q_len: got %0d expected 256", cap_len); end
        n_vec++; if (len_err !== 1'b1) begin n_err++; $display("FAIL clamp_len_err: got %b expected 1", len_err); end
        stream_write(256, 1'b0);
        check_read("clamp", 256);
        finish_txn(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL clamp_done_lat: got %0d expected 1", lat); end
    endtask

    task automatic test_len_zero;
        bit saw_cmd = 1'b0;
        int done_at = -1;
        @(negedge clk);
        address_valid = 1'b1; address = 24'($urandom); length_valid = 1'b1; length = 9'd0; ena = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            address_valid = 1'b0; length_valid = 1'b0;
            #1;
            if (q_cmd_valid) saw_cmd = 1'b1;
            if (txn_done && done_at < 0) done_at = i;
        end
        n_vec++; if (saw_cmd) begin n_err++; $display("FAIL len0_cmd: got 1 expected 0"); end
        n_vec++; if (done_at < 1 || done_at > 3) begin n_err++; $display("FAIL len0_done: got %0d expected 1..3", done_at); end
    endtask

    task automatic test_reset_mid_read;
        open_txn(24'($urandom), 9'd16, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_ready = 1'b1; q_rvalid = 1'b1; q_rdata = 8'($urandom);
        end
        @(negedge clk);
        q_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (txn_done !== 1'b1) begin n_err++; $display("FAIL rstmid_txn_done: got %b expected 1", txn_done); end
        n_vec++; if ({rd_valid, len_err, q_rw, q_cmd_valid} !== 4'b0) begin
            n_err++; $display("FAIL rstmid_flags: got %b expected 0000", {rd_valid, len_err, q_rw, q_cmd_valid}); end
        n_vec++; if ({q_addr, q_len} !== 33'b0) begin n_err++; $display("FAIL rstmid_fields: got %h expected 0", {q_addr, q_len}); end
        @(negedge clk) rst_n = 1'b1;
        test_read16();
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [23:0] a2;
        open_txn(24'($urandom), 9'd4, 1'b0, 1'b1, 1'b0);
        stream_write(4, 1'b0);
        finish_txn(lat);
        a2 = 24'($urandom);
        open_txn(a2, 9'd8, 1'b1, 1'b1, 1'b1);
        n_vec++; if (!cap_seen || cmd_lat != 2 || cap_addr !== a2) begin
            n_err++; $display("FAIL b2b_cmd: got seen=%b lat=%0d addr=%h expected seen=1 lat=2 addr=%h",
                              cap_seen, cmd_lat, cap_addr, a2); end
        stream_read(8, 3, 3);
        check_read("b2b", 8);
        finish_txn(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL b2b_done_lat: got %0d expected 1", lat); end
    endtask

`ifdef MEM_TXN_TIMEOUT_EN
    task automatic test_timeout;
        int hit_at = -1;
        open_txn(24'($urandom), 9'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (timeout) begin hit_at = i; break; end
        end
        n_vec++; if (hit_at != 16) begin n_err++; $display("FAIL timeout_cycles: got %0d expected 16", hit_at); end
        n_vec++; if (txn_done !== 1'b1) begin n_err++; $display("FAIL timeout_idle: got %b expected 1", txn_done); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; ena = 1'b0; r_w = 1'b0; address_valid = 1'b0; address = '0;
        length_valid = 1'b0; length = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
        q_cmd_ready = 1'b0; q_wready = 1'b0; q_rdata = '0; q_rvalid = 1'b0; q_done = 1'b0;
        test_reset();
        test_read16();
        test_write32();
        test_read_backpressure();
        test_len_clamp();
        test_len_zero();
        test_reset_mid_read();
        test_back_to_back();
`ifdef MEM_TXN_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_txn_fsm.md
# mem_txn_fsm

Memory-side transaction engine directly downstream of the host command port. Latches the address, length and direction the command port issues, launches one QSPI transfer per command, streams bytes between the command port's FSM byte bus and the QSPI controller through a 4-entry read buffer, and reports completion through `txn_done`.

## Interface

- `MAX_LEN`, 256: largest byte count accepted per transaction.
- `RBUF_DEPTH`, 4: read-buffer entries (power of two, at least 2).
- `TIMEOUT_CYC`, 1024: stall limit (only with `MEM_TXN_TIMEOUT_EN`).

- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: command-port transaction enable.
- `r_w` in 1: 1 = read from memory, 0 = write to memory.
- `address_valid` in 1: one-cycle strobe that latches `address`.
- `address` in 24: byte address.
- `length_valid` in 1: one-cycle strobe that latches `length`.
- `length` in 9: byte count.
- `wr_data` in 8: write byte from the command port.
- `wr_valid` in 1: `wr_data` valid.
- `wr_ready` out 1: engine accepts `wr_data`.
- `rd_data` out 8: read byte to the command port.
- `rd_valid` out 1: `rd_data` valid.
- `rd_ready` in 1: command port accepts `rd_data`.
- `txn_done` out 1: high while idle (no transaction open).
- `len_err` out 1: sticky flag, length was clamped.
- `timeout` out 1: sticky flag, watchdog abort (0 when the macro is absent).
- `q_cmd_valid` out 1, `q_cmd_ready` in 1: QSPI command handshake.
- `q_rw` out 1, `q_addr` out 24, `q_len` out 9: QSPI command fields.
- `q_wdata` out 8, `q_wvalid` out 1, `q_wready` in 1: QSPI write byte stream.
- `q_rdata` in 8, `q_rvalid` in 1: QSPI read byte stream. No backpressure; the engine guarantees space.
- `q_done` in 1: QSPI end-of-transfer pulse.

## Operation

- Every transfer on a valid/ready pair happens in a cycle where both are high.
- States:
  - IDLE → ARM when `address_valid` is seen.
  - ARM → ISSUE when `ena` is high and a length has been latched (`length_valid` may arrive in the same cycle as the address or later).
  - ISSUE → WDATA or RDATA on the `q_cmd_valid`/`q_cmd_ready` handshake.
  - WDATA or RDATA → DRAIN once `q_len` bytes have moved.
  - DRAIN → IDLE when `q_done` is seen and the read buffer is empty.
- Length rules:
  - `q_len` = min(`length`, `MAX_LEN`). If clamped, `len_err` is set.
  - Length 0: go ARM → IDLE directly, issue no QSPI command.
- Direction is latched from `r_w` on entry to ISSUE.
- Write path: `wr_data` passes combinationally to `q_wdata`.
  - `q_wvalid` = `wr_valid` gated by state WDATA.
  - `wr_ready` = `q_wready` gated by state WDATA.
- Read path:
  - `q_rdata` is pushed into the read buffer. `rd_*` comes from the buffer head.
  - Bytes are requested from QSPI only while fewer than `RBUF_DEPTH` bytes are outstanding; the QSPI controller stalls its clock when that limit is reached.
  - Push and pop in the same cycle keep the count unchanged.
  - `q_rvalid` while the buffer is full, or outside RDATA, is dropped and sets `len_err`.
- A 9-bit byte counter counts up per handshake. A transfer is complete when the counter equals `q_len`.
- Deasserting `ena` mid-transfer has no effect. Transactions are not abortable except by reset or timeout.
- Reset values: all outputs 0 except `txn_done`=1. State is IDLE, buffer empty, flags cleared, latched fields 0.

## Timing

- `q_cmd_valid` rises the cycle after ARM is satisfied and stays high until accepted.
- Write bytes: zero-cycle passthrough.
- Read bytes: `rd_valid` rises 1 cycle after `q_rvalid`, because the buffer is registered.
- `txn_done` falls the cycle after `address_valid` and rises the cycle after DRAIN exits.
- Back-to-back: a new `address_valid` is accepted in the first IDLE cycle.

## Configuration

- `MEM_TXN_TIMEOUT_EN` defined:
  - A counter clears on every byte handshake or state change.
  - If it reaches `TIMEOUT_CYC` in ISSUE, WDATA, RDATA or DRAIN, the engine sets `timeout`, flushes the read buffer and returns to IDLE.
- Undefined: no counter, `timeout` tied 0, stalls wait forever.

## Test plan

- Read 16 bytes at address 0x00_1234 with `rd_ready`=1: `q_addr`=0x001234, `q_len`=16, `q_rw`=1. The 16 `q_rdata` bytes appear in order on `rd_data`, each 1 cycle later. `txn_done` returns high after `q_done`.
- Write 32 bytes, `q_wready` toggling every other cycle: exactly 32 handshakes on both sides with matching data. No extra `q_wvalid` after byte 32.
- Read 32 bytes with `rd_ready` held low for 10 cycles mid-stream: the buffer fills to 4, no `q_rvalid` is dropped, `len_err` stays 0, all 32 bytes are delivered in order.
- `length`=300: `q_len`=256 and `len_err`=1. `length`=0: no `q_cmd_valid`, `txn_done` high again within 3 cycles.
- Reset asserted during RDATA after 5 bytes: outputs go to reset values immediately, including `txn_done`=1. The next 16-byte read completes normally.
- With `MEM_TXN_TIMEOUT_EN` and `TIMEOUT_CYC`=16, hold `q_cmd_ready`=0: `timeout`=1 and the engine is idle after 16 cycles in ISSUE.
